pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// multi-cycle data-memory waits with timeout, and a saturating stall counter.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [WaitW-1:0]   r_wait_cnt;
  logic [WaitW-1:0]   w_wait_cnt_next;
  logic               r_err;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_load_use;
  logic               w_freeze;
  logic               w_resolve;

  assign w_load_use = ex_memRead && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  assign state           = r_state;
  assign mem_timeout_err = r_err;
  assign stall_count     = r_stall_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StRun;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    unique case (r_state)
      StRun: begin
        if (mem_access && !dmem_ack) begin
          w_state_next    = StMemWait;
          w_wait_cnt_next = '0;
        end
      end
      StMemWait: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (dmem_ack) begin
          w_state_next    = StRun;
          w_wait_cnt_next = '0;
        end else if (r_wait_cnt == WaitLast) begin
          w_state_next = StError;
        end else begin
          w_wait_cnt_next = r_wait_cnt + WaitW'(1);
        end
      end
      StError: begin
        w_state_next = StError;
      end
      default: begin
        w_state_next    = StRun;
        w_wait_cnt_next = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    dmem_req     = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    w_freeze     = 1'b0;
    w_resolve    = 1'b0;

    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      unique case (r_state)
        StRun: begin
          dmem_req  = mem_access;
          w_freeze  = mem_access && !dmem_ack;
          w_resolve = !w_freeze;
        end
        StMemWait: begin
          dmem_req  = 1'b1;
          w_freeze  = !dmem_ack;
          w_resolve = dmem_ack;
        end
        StError: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
        default: begin
          dmem_req = 1'b0;
        end
      endcase

      // The memory stage drains a bubble while everything upstream holds.
      if (w_freeze) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (w_resolve) begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  // Sticky timeout flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_state_next == StError) begin
        r_err <= 1'b1;
      end
      if (!pc_en && (r_state != StError) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: the driver queues the expected per-cycle
// outputs, the monitor pops and compares them on the falling edge.
module tb_pipeline_ctrl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 4;

  // Packed control order: req pc ifid_en ifid_fl idex_en idex_fl exmem memwb_en memwb_fl
  localparam logic [8:0] CNorm  = 9'b011010110;
  localparam logic [8:0] CRst   = 9'b000101001;
  localparam logic [8:0] CLu    = 9'b000011110;
  localparam logic [8:0] CBr    = 9'b011111110;
  localparam logic [8:0] CFrz   = 9'b100000011;
  localparam logic [8:0] CAck   = 9'b111010110;
  localparam logic [8:0] CAckBr = 9'b111111110;
  localparam logic [8:0] CAckLu = 9'b100011110;
  localparam logic [8:0] CErr   = 9'b000000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic id_uses_rt = 1'b0;
  logic ex_memRead = 1'b0;
  logic [4:0] ex_rd = '0;
  logic ex_branch_taken = 1'b0;
  logic mem_access = 1'b1;
  logic dmem_ack = 1'b0;
  logic dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_en, mem_wb_flush, mem_timeout_err;
  logic [CntW-1:0] stall_count;
  logic [1:0] state;

  typedef struct {
    string      nm;
    logic [8:0] ctrl;
    logic [1:0] st;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_memRead     (ex_memRead),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_access     (mem_access),
    .dmem_ack       (dmem_ack),
    .dmem_req       (dmem_req),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_en       (id_ex_en),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .mem_wb_flush   (mem_wb_flush),
    .mem_timeout_err(mem_timeout_err),
    .stall_count    (stall_count),
    .state          (state)
  );

  // Drive one cycle's inputs just after the rising edge and queue what that cycle must show.
  task automatic step(input string nm, input logic rst, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic mr,
                      input logic [4:0] rd, input logic br, input logic ma, input logic ack,
                      input logic [8:0] ec, input logic [1:0] es, input logic ee,
                      input logic [3:0] en);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memRead = mr;
    ex_rd = rd; ex_branch_taken = br; mem_access = ma; dmem_ack = ack;
    e.nm = nm; e.ctrl = ec; e.st = es; e.err = ee; e.cnt = en;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [3:0] en);
    step(nm, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CNorm, 2'd0, 1'b0, en);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, mem_wb_flush};
        n_tests++;
        if (act !== e.ctrl || state !== e.st || mem_timeout_err !== e.err ||
            stall_count !== e.cnt) begin
          n_fail++;
          $display("FAIL %s: got ctrl=%b st=%0d err=%b cnt=%0d, expected ctrl=%b st=%0d err=%b cnt=%0d",
                   e.nm, act, state, mem_timeout_err, stall_count,
                   e.ctrl, e.st, e.err, e.cnt);
        end
      end
    end
  end

  // Driver
  initial begin
    //    name           rst  rs     rt    urt  mr   rd    br   ma   ack  ctrl    st    err  cnt
    step("reset0",       1, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CRst,   2'd0, 0, 4'd0);
    step("reset1",       1, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CRst,   2'd0, 0, 4'd0);
    idle("post_reset", 4'd0);
    step("load_use_rs",  0, 5'd8,  5'd0,  0,   1,  5'd8,  0,   0,   0,  CLu,    2'd0, 0, 4'd0);
    idle("after_lu", 4'd1);
    step("rd_zero",      0, 5'd0,  5'd0,  1,   1,  5'd0,  0,   0,   0,  CNorm,  2'd0, 0, 4'd1);
    step("load_use_rt",  0, 5'd3,  5'd9,  1,   1,  5'd9,  0,   0,   0,  CLu,    2'd0, 0, 4'd1);
    step("rt_unused",    0, 5'd3,  5'd9,  0,   1,  5'd9,  0,   0,   0,  CNorm,  2'd0, 0, 4'd2);
    step("branch_lu",    0, 5'd8,  5'd0,  0,   1,  5'd8,  1,   0,   0,  CBr,    2'd0, 0, 4'd2);
    idle("after_br", 4'd2);
    // Three-cycle memory wait
    step("mem_req",      0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd0, 0, 4'd2);
    step("mem_wait1",    0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd3);
    step("mem_wait2",    0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd4);
    step("mem_ack",      0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   1,  CAck,   2'd1, 0, 4'd5);
    idle("after_mem", 4'd5);
    // Branch pending during a wait: flush applied on the ack cycle
    step("br_mem_req",   0, 5'd0,  5'd0,  0,   0,  5'd0,  1,   1,   0,  CFrz,   2'd0, 0, 4'd5);
    step("br_mem_ack",   0, 5'd0,  5'd0,  0,   0,  5'd0,  1,   1,   1,  CAckBr, 2'd1, 0, 4'd6);
    idle("after_brmem", 4'd6);
    // Load-use pending during a wait
    step("lu_mem_req",   0, 5'd8,  5'd0,  0,   1,  5'd8,  0,   1,   0,  CFrz,   2'd0, 0, 4'd6);
    step("lu_mem_ack",   0, 5'd8,  5'd0,  0,   1,  5'd8,  0,   1,   1,  CAckLu, 2'd1, 0, 4'd7);
    idle("after_lumem", 4'd8);
    step("mem_fast",     0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   1,  CAck,   2'd0, 0, 4'd8);
    step("mem_fast_lu",  0, 5'd8,  5'd0,  0,   1,  5'd8,  0,   1,   1,  CAckLu, 2'd0, 0, 4'd8);
    idle("after_fast", 4'd9);
    // Ack on the last allowed wait cycle
    step("edge_req",     0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd0, 0, 4'd9);
    step("edge_w0",      0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd10);
    step("edge_w1",      0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd11);
    step("edge_w2",      0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd12);
    step("edge_w3_ack",  0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   1,  CAck,   2'd1, 0, 4'd13);
    idle("edge_back_run", 4'd13);
    step("reset_mid",    1, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,   0,  CRst,   2'd0, 0, 4'd13);
    idle("cleared", 4'd0);
    // Timeout: no ack within the allowed window
    step("to_req",       0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd0, 0, 4'd0);
    step("to_w0",        0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd1);
    step("to_w1",        0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd2);
    step("to_w2",        0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd3);
    step("to_w3",        0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd4);
    step("err0",         0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CErr,   2'd2, 1, 4'd5);
    step("err_ack",      0, 5'd0,  5'd0,  0,   0,  5'd0,  1,   1,   1,  CErr,   2'd2, 1, 4'd5);
    step("err_lu",       0, 5'd8,  5'd0,  0,   1,  5'd8,  0,   0,   0,  CErr,   2'd2, 1, 4'd5);
    step("err_reset",    1, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,   0,  CRst,   2'd2, 1, 4'd5);
    idle("err_cleared", 4'd0);
    // Reset while waiting drops the request immediately
    step("rw_req",       0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd0, 0, 4'd0);
    step("rw_w0",        0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CFrz,   2'd1, 0, 4'd1);
    step("rw_reset",     1, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,   0,  CRst,   2'd1, 0, 4'd2);
    idle("rw_cleared", 4'd0);
    // Saturation of the 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      step("sat_lu", 0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0, CLu, 2'd0, 0,
           (i > 15) ? 4'd15 : 4'(i));
    end
    idle("sat_hold", 4'd15);

    // Bounded drain of the scoreboard
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
